// File: rtl/block_noise_estimator.sv
// Per-8x8-block pixel variance and per-frame minimum-variance noise estimate.
// Optional macro NOISE_SKIP_FLAT_EN excludes zero-variance blocks from the minimum.
module block_noise_estimator #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           frame_height,
   input  logic [15:0]           frame_width,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  noise_estimation_en,
   input  logic                  start_data,
   input  logic                  start_of_frame,
   output logic [15:0]           block_var,
   output logic                  block_var_valid,
   output logic [15:0]           estimated_noise,
   output logic                  estimated_noise_ready,
   output logic                  sync_err
);

   localparam int         PIX_PER_BLK = BLOCK_SIZE * BLOCK_SIZE;
   localparam logic [5:0] LAST_IDX    = 6'(PIX_PER_BLK - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

   state_t      r_state;
   logic [13:0] r_s;
   logic [21:0] r_q;
   logic [5:0]  r_cnt;
   logic [13:0] r_sf;
   logic [21:0] r_qf;
   logic        r_v0;
   logic [27:0] r_q64;
   logic [27:0] r_ss;
   logic        r_v1;
   logic [15:0] r_bpf;
   logic [15:0] r_blk_cnt;
   logic [15:0] r_min;

   logic [7:0]  w_p;
   logic [15:0] w_pp;
   logic        w_acc;
   logic        w_sof;
   logic        w_pix;
   logic        w_start;
   logic        w_err;
   logic        w_last;
   logic        w_frame_end;
   logic [15:0] w_bpf;
   logic [27:0] w_diff;
   logic        w_take;
   logic [15:0] w_min_next;
   logic [15:0] w_est;
   logic        w_unused_bits;

   assign w_p     = data_in[7:0];
   assign w_pp    = {8'd0, w_p} * {8'd0, w_p};
   assign w_acc   = data_valid & noise_estimation_en;
   assign w_sof   = w_acc & start_of_frame;
   // Outside a frame only the frame-start pixel itself is taken.
   assign w_pix   = w_acc & (start_of_frame | (r_state == ACCUM));
   assign w_start = start_data | start_of_frame;
   assign w_err   = w_pix & start_data & (r_cnt != 6'd0);
   assign w_last  = w_pix & ~w_start & (r_cnt == LAST_IDX);
   assign w_frame_end = w_last & ((r_blk_cnt + 16'd1) == r_bpf);
   assign w_bpf   = {3'd0, frame_height[15:3]} * {3'd0, frame_width[15:3]};
   assign w_diff  = r_q64 - r_ss;
   assign w_unused_bits = ^{data_in[DATA_WIDTH-1:8], frame_height[2:0], frame_width[2:0]};

`ifdef NOISE_SKIP_FLAT_EN
   assign w_take = block_var_valid & (block_var != 16'd0);
   assign w_est  = (w_min_next == 16'hFFFF) ? 16'd0 : w_min_next;
`else
   assign w_take = block_var_valid;
   assign w_est  = w_min_next;
`endif
   assign w_min_next = (w_take && (block_var < r_min)) ? block_var : r_min;

   // Block accumulators; final sums are handed off so the next block can start at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s   <= '0;
         r_q   <= '0;
         r_cnt <= '0;
         r_sf  <= '0;
         r_qf  <= '0;
         r_v0  <= 1'b0;
      end else begin
         r_v0 <= 1'b0;
         if (w_pix && w_start) begin
            r_s   <= {6'd0, w_p};
            r_q   <= {6'd0, w_pp};
            r_cnt <= 6'd1;
         end else if (w_last) begin
            r_sf  <= r_s + {6'd0, w_p};
            r_qf  <= r_q + {6'd0, w_pp};
            r_v0  <= 1'b1;
            r_cnt <= 6'd0;
         end else if (w_pix && (r_cnt != 6'd0)) begin
            r_s   <= r_s + {6'd0, w_p};
            r_q   <= r_q + {6'd0, w_pp};
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   // A new frame start kills in-flight results so they never reach the new minimum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q64           <= '0;
         r_ss            <= '0;
         r_v1            <= 1'b0;
         block_var       <= '0;
         block_var_valid <= 1'b0;
      end else begin
         r_v1            <= r_v0 & ~w_sof;
         block_var_valid <= r_v1 & ~w_sof;
         if (r_v0) begin
            r_q64 <= {r_qf, 6'd0};
            r_ss  <= {14'd0, r_sf} * {14'd0, r_sf};
         end
         if (r_v1) begin
            block_var <= w_diff[27:12];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_err <= 1'b0;
      end else if (w_sof) begin
         sync_err <= w_err;
      end else if (w_err) begin
         sync_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state               <= IDLE;
         r_bpf                 <= '0;
         r_blk_cnt             <= '0;
         r_min                 <= 16'hFFFF;
         estimated_noise       <= '0;
         estimated_noise_ready <= 1'b0;
      end else begin
         estimated_noise_ready <= 1'b0;
         if (w_sof) begin
            r_bpf     <= w_bpf;
            r_blk_cnt <= '0;
            r_min     <= 16'hFFFF;
            r_state   <= ACCUM;
         end else begin
            if ((r_state == ACCUM) || (r_state == FLUSH)) begin
               r_min <= w_min_next;
            end
            case (r_state)
               IDLE: r_state <= IDLE;
               ACCUM: begin
                  if (w_last) begin
                     r_blk_cnt <= r_blk_cnt + 16'd1;
                     if (w_frame_end) begin
                        r_state <= FLUSH;
                     end
                  end
               end
               FLUSH: begin
                  if (block_var_valid) begin
                     r_state               <= DONE;
                     estimated_noise       <= w_est;
                     estimated_noise_ready <= 1'b1;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_block_noise_estimator.sv
// Directed bench for block_noise_estimator: block variances, frame minimum, sync errors, aborts, reset.
// Expectations follow NOISE_SKIP_FLAT_EN when the bench is built with it.
module tb_block_noise_estimator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] frame_height;
   logic [15:0] frame_width;
   logic [31:0] data_in;
   logic        data_valid;
   logic        noise_estimation_en;
   logic        start_data;
   logic        start_of_frame;
   logic [15:0] block_var;
   logic        block_var_valid;
   logic [15:0] estimated_noise;
   logic        estimated_noise_ready;
   logic        sync_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_edge = 0;

   logic [15:0] bv_q[$];
   int          bvc_q[$];
   logic [15:0] en_q[$];

   block_noise_estimator #(.DATA_WIDTH(32), .BLOCK_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .frame_height(frame_height), .frame_width(frame_width),
      .data_in(data_in), .data_valid(data_valid),
      .noise_estimation_en(noise_estimation_en),
      .start_data(start_data), .start_of_frame(start_of_frame),
      .block_var(block_var), .block_var_valid(block_var_valid),
      .estimated_noise(estimated_noise), .estimated_noise_ready(estimated_noise_ready),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (block_var_valid === 1'b1) begin
         bv_q.push_back(block_var);
         bvc_q.push_back(cyc);
      end
      if (estimated_noise_ready === 1'b1) begin
         en_q.push_back(estimated_noise);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   function automatic logic [7:0] pix(input int kind, input int i);
      case (kind)
         0:       return 8'd100;
         1:       return ((((i >> 3) + i) & 1) != 0) ? 8'd255 : 8'd0;
         2:       return 8'(i);
         default: return 8'd255;
      endcase
   endfunction

   task automatic drive(input logic [7:0] p, input logic dv, input logic en,
                        input logic sd, input logic sof);
      data_in = {24'd0, p};
      data_valid = dv;
      noise_estimation_en = en;
      start_data = sd;
      start_of_frame = sof;
      @(posedge clk);
      #1;
      last_edge = cyc;
   endtask

   task automatic idle(input int n);
      data_in = 32'd0;
      data_valid = 1'b0;
      noise_estimation_en = 1'b0;
      start_data = 1'b0;
      start_of_frame = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_block(input int kind, input logic sof);
      for (int i = 0; i < 64; i++) drive(pix(kind, i), 1'b1, 1'b1, i == 0, sof && (i == 0));
   endtask

   task automatic clear_q();
      bv_q.delete();
      bvc_q.delete();
      en_q.delete();
   endtask

   task automatic wait_ready(input int budget);
      data_valid = 1'b0;
      start_data = 1'b0;
      start_of_frame = 1'b0;
      for (int k = 0; k < budget && en_q.size() == 0; k++) @(posedge clk);
      idle(4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      frame_height = 16'd8;
      frame_width = 16'd8;
      idle(3);
      checks++; if (block_var !== 16'd0) begin errors++; $display("FAIL reset_block_var: got %0d expected 0", block_var); end
      checks++; if (block_var_valid !== 1'b0) begin errors++; $display("FAIL reset_bv_valid: got %b expected 0", block_var_valid); end
      checks++; if (estimated_noise !== 16'd0) begin errors++; $display("FAIL reset_est: got %0d expected 0", estimated_noise); end
      checks++; if (estimated_noise_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", estimated_noise_ready); end
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
      rst_n = 1'b1;
      idle(2);
      $display("test_reset done");
   endtask

   task automatic test_idle_ignore();
      clear_q();
      send_block(2, 1'b0);
      idle(10);
      checks++; if (bv_q.size() != 0) begin errors++; $display("FAIL idle_ignore_bv: got %0d results expected 0", bv_q.size()); end
      checks++; if (en_q.size() != 0) begin errors++; $display("FAIL idle_ignore_est: got %0d results expected 0", en_q.size()); end
      $display("test_idle_ignore done");
   endtask

   task automatic test_single(input int kind, input logic [15:0] exp, input logic gaps);
      logic [15:0] v;
      int e0;
      clear_q();
      frame_height = 16'd8;
      frame_width = 16'd8;
      for (int i = 0; i < 64; i++) begin
         if (gaps && i > 0 && (i % 5) == 2) drive(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
         if (gaps && i > 0 && (i % 7) == 3) drive(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
         drive(pix(kind, i), 1'b1, 1'b1, i == 0, i == 0);
      end
      e0 = last_edge;
      wait_ready(20);
      checks++; if (bv_q.size() != 1) begin errors++; $display("FAIL single%0d_count: got %0d results expected 1", kind, bv_q.size()); end
      v = (bv_q.size() > 0) ? bv_q[0] : 16'hxxxx;
      checks++; if (v !== exp) begin errors++; $display("FAIL single%0d_var: got %0d expected %0d", kind, v, exp); end
      checks++;
      if (bvc_q.size() == 0 || (bvc_q[0] - (e0 - 1)) != 3) begin
         errors++; $display("FAIL single%0d_latency: got %0d cycles expected 3", kind, (bvc_q.size() > 0) ? bvc_q[0] - (e0 - 1) : -1);
      end
      checks++; if (en_q.size() != 1) begin errors++; $display("FAIL single%0d_ready_pulses: got %0d expected 1", kind, en_q.size()); end
      checks++; if (estimated_noise !== exp) begin errors++; $display("FAIL single%0d_est: got %0d expected %0d", kind, estimated_noise, exp); end
      $display("test_single kind=%0d var=%0d", kind, v);
   endtask

   task automatic test_frame_back_to_back();
      logic [15:0] exp_v[4];
      logic [15:0] exp_est;
      logic [15:0] v;
      exp_v[0] = 16'd341; exp_v[1] = 16'd16256; exp_v[2] = 16'd0; exp_v[3] = 16'd341;
`ifdef NOISE_SKIP_FLAT_EN
      exp_est = 16'd341;
`else
      exp_est = 16'd0;
`endif
      clear_q();
      frame_height = 16'd16;
      frame_width = 16'd16;
      send_block(2, 1'b1);
      send_block(1, 1'b0);
      send_block(0, 1'b0);
      send_block(2, 1'b0);
      wait_ready(30);
      checks++; if (bv_q.size() != 4) begin errors++; $display("FAIL frame_count: got %0d results expected 4", bv_q.size()); end
      for (int k = 0; k < 4; k++) begin
         v = (bv_q.size() > k) ? bv_q[k] : 16'hxxxx;
         checks++; if (v !== exp_v[k]) begin errors++; $display("FAIL frame_var%0d: got %0d expected %0d", k, v, exp_v[k]); end
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (bvc_q.size() <= k || (bvc_q[k] - bvc_q[k-1]) != 64) begin
            errors++; $display("FAIL frame_spacing%0d: got %0d expected 64", k, (bvc_q.size() > k) ? bvc_q[k] - bvc_q[k-1] : -1);
         end
      end
      checks++; if (en_q.size() != 1) begin errors++; $display("FAIL frame_ready_pulses: got %0d expected 1", en_q.size()); end
      v = (en_q.size() > 0) ? en_q[0] : 16'hxxxx;
      checks++; if (v !== exp_est) begin errors++; $display("FAIL frame_est_at_ready: got %0d expected %0d", v, exp_est); end
      checks++; if (estimated_noise !== exp_est) begin errors++; $display("FAIL frame_est_held: got %0d expected %0d", estimated_noise, exp_est); end
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL frame_sync_err: got %b expected 0", sync_err); end
      $display("test_frame_back_to_back est=%0d", estimated_noise);
   endtask

   task automatic test_sync_err();
      logic [15:0] v;
      clear_q();
      frame_height = 16'd8;
      frame_width = 16'd8;
      for (int i = 0; i < 20; i++) drive(8'd255, 1'b1, 1'b1, i == 0, i == 0);
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_before: got %b expected 0", sync_err); end
      for (int i = 0; i < 64; i++) begin
         drive(pix(2, i), 1'b1, 1'b1, i == 0, 1'b0);
         if (i == 0) begin
            checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set: got %b expected 1", sync_err); end
         end
      end
      wait_ready(20);
      checks++; if (bv_q.size() != 1) begin errors++; $display("FAIL sync_count: got %0d results expected 1", bv_q.size()); end
      v = (bv_q.size() > 0) ? bv_q[0] : 16'hxxxx;
      checks++; if (v !== 16'd341) begin errors++; $display("FAIL sync_var: got %0d expected 341", v); end
      checks++; if (estimated_noise !== 16'd341) begin errors++; $display("FAIL sync_est: got %0d expected 341", estimated_noise); end
      checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky: got %b expected 1", sync_err); end
      $display("test_sync_err var=%0d sync_err=%b", v, sync_err);
   endtask

   task automatic test_abort();
      logic [15:0] v;
      clear_q();
      frame_height = 16'd16;
      frame_width = 16'd16;
      for (int i = 0; i < 64; i++) begin
         drive(pix(0, i), 1'b1, 1'b1, i == 0, i == 0);
         if (i == 0) begin
            checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL abort_sof_clears_sync: got %b expected 0", sync_err); end
         end
      end
      frame_height = 16'd8;
      frame_width = 16'd8;
      send_block(2, 1'b1);
      wait_ready(30);
      checks++; if (bv_q.size() != 1) begin errors++; $display("FAIL abort_count: got %0d results expected 1", bv_q.size()); end
      v = (bv_q.size() > 0) ? bv_q[0] : 16'hxxxx;
      checks++; if (v !== 16'd341) begin errors++; $display("FAIL abort_var: got %0d expected 341", v); end
      checks++; if (en_q.size() != 1) begin errors++; $display("FAIL abort_ready_pulses: got %0d expected 1", en_q.size()); end
      checks++; if (estimated_noise !== 16'd341) begin errors++; $display("FAIL abort_est: got %0d expected 341", estimated_noise); end
      $display("test_abort est=%0d", estimated_noise);
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      clear_q();
      frame_height = 16'd16;
      frame_width = 16'd16;
      for (int i = 0; i < 30; i++) drive(pix(1, i), 1'b1, 1'b1, i == 0, i == 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (block_var !== 16'd0) begin errors++; $display("FAIL midrst_block_var: got %0d expected 0", block_var); end
      checks++; if (estimated_noise !== 16'd0) begin errors++; $display("FAIL midrst_est: got %0d expected 0", estimated_noise); end
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL midrst_sync_err: got %b expected 0", sync_err); end
      checks++; if ({block_var_valid, estimated_noise_ready} !== 2'b00) begin errors++; $display("FAIL midrst_pulses: got %b expected 00", {block_var_valid, estimated_noise_ready}); end
      idle(2);
      rst_n = 1'b1;
      idle(1);
      clear_q();
      frame_height = 16'd8;
      frame_width = 16'd8;
      send_block(1, 1'b1);
      wait_ready(20);
      checks++; if (bv_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d results expected 1", bv_q.size()); end
      v = (bv_q.size() > 0) ? bv_q[0] : 16'hxxxx;
      checks++; if (v !== 16'd16256) begin errors++; $display("FAIL midrst_var: got %0d expected 16256", v); end
      checks++; if (estimated_noise !== 16'd16256) begin errors++; $display("FAIL midrst_est_after: got %0d expected 16256", estimated_noise); end
      $display("test_reset_mid est=%0d", estimated_noise);
   endtask

   initial begin
      data_in = 32'd0;
      data_valid = 1'b0;
      noise_estimation_en = 1'b0;
      start_data = 1'b0;
      start_of_frame = 1'b0;
      test_reset();
      test_idle_ignore();
      test_single(0, 16'd0, 1'b0);
      test_single(1, 16'd16256, 1'b0);
      test_single(2, 16'd341, 1'b1);
      test_frame_back_to_back();
      test_sync_err();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/block_noise_estimator.md
BLOCK_NOISE_ESTIMATOR -- requirements
Module: block_noise_estimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of read-data word; pixel is bits [7:0].
REQ-002 SHALL have parameter BLOCK_SIZE, default 8: block edge in pixels; only 8 supported.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_height, input, 16: frame rows, multiple of 8, at most 720.
REQ-006 SHALL have port frame_width, input, 16: frame columns, multiple of 8, at most 1280.
REQ-007 SHALL have port data_in, input, DATA_WIDTH: pixel word from the memory read channel.
REQ-008 SHALL have port data_valid, input, 1: data_in carries a pixel (AXI rvalid).
REQ-009 SHALL have port noise_estimation_en, input, 1: pixel acceptance gate from the block reader.
REQ-010 SHALL have port start_data, input, 1: marks the first pixel of each 8x8 block.
REQ-011 SHALL have port start_of_frame, input, 1: marks the first pixel of the frame.
REQ-012 SHALL have port block_var, output, 16: variance of the last completed block.
REQ-013 SHALL have port block_var_valid, output, 1: one-cycle pulse qualifying block_var.
REQ-014 SHALL have port estimated_noise, output, 16: frame noise estimate, held until the next frame result.
REQ-015 SHALL have port estimated_noise_ready, output, 1: one-cycle pulse when estimated_noise updates.
REQ-016 SHALL have port sync_err, output, 1: sticky block-framing error flag.

Function
REQ-017 SHALL accept a pixel on a cycle with data_valid=1 and noise_estimation_en=1; all other cycles are ignored.
REQ-018 SHALL accumulate per block: S (14 b) = sum of pixels; Q (22 b) = sum of pixel squares; 6-bit pixel counter.
REQ-019 SHALL, on an accepted pixel with start_data=1, load S=p, Q=p*p, count=1.
REQ-020 SHALL, on the 64th accepted pixel, launch a 2-stage pipeline: stage 1 computes 64*Q and S*S (28 b each); stage 2 computes block_var = (64*Q - S*S) >> 12, truncated.
REQ-021 SHALL pulse block_var_valid exactly 3 cycles after the 64th pixel is accepted; back-to-back blocks with zero gap SHALL be supported.
REQ-022 SHALL, on an accepted start_of_frame pixel, latch blocks_per_frame = (frame_height>>3)*(frame_width>>3), clear the block count, and set running minimum to 16'hFFFF.
REQ-023 SHALL use FSM states IDLE, ACCUM, FLUSH, DONE: IDLE->ACCUM on accepted start_of_frame; ACCUM->FLUSH when the last block's 64th pixel is accepted; FLUSH->DONE when its block_var_valid fires; DONE->IDLE unconditionally after 1 cycle.
REQ-024 SHALL update running minimum on each block_var_valid; in DONE, SHALL drive estimated_noise = minimum and pulse estimated_noise_ready.
REQ-025 SHALL, on start_data while count is 1..63, discard the partial block, restart accumulation, and set sync_err.
REQ-026 SHALL, on start_of_frame while in ACCUM/FLUSH, abort the current frame with no estimate and restart; blocks already in the pipeline SHALL NOT affect the new minimum.
REQ-027 SHALL ignore pixels accepted in IDLE without start_of_frame.
REQ-028 SHALL clear sync_err only on an accepted start_of_frame with no simultaneous error.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: state IDLE; block_var=0; block_var_valid=0; estimated_noise=0; estimated_noise_ready=0; sync_err=0; all accumulators, counters and pipeline valids 0.
REQ-030 SHALL discard any partial block or frame in progress when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, with macro NOISE_SKIP_FLAT_EN defined, exclude blocks with block_var=0 from the minimum; if all blocks are flat, estimated_noise=0.
REQ-032 SHALL, without NOISE_SKIP_FLAT_EN, include every block in the minimum.

Verification
REQ-033 Single block, all pixels 100 -> block_var=0, block_var_valid 3 cycles after the 64th pixel.
REQ-034 Single block, checkerboard 0/255 -> block_var=16256.
REQ-035 Single block, ramp 0..63 -> block_var=341.
REQ-036 16x16 frame, block variances 341, 16256, 0, 341 -> estimated_noise=0 without macro, 341 with NOISE_SKIP_FLAT_EN; one-cycle ready pulse.
REQ-037 start_data at pixel 20 of a block -> sync_err=1, partial block dropped, next 64 pixels give the correct block_var.
REQ-038 rst_n low mid-block, then a fresh frame -> all outputs 0 during reset, correct estimate afterwards.
